// File: rtl/mips_run_controller.sv
// mips_run_controller
//
// Run controller for the single-cycle MIPS core. It holds the core in reset,
// streams a program image into instruction memory through a write port, then
// releases the core and counts run cycles until the core fetches the halt word
// (or, optionally, a cycle limit expires).
//
// Optional feature macro: RUN_CTRL_TIMEOUT_EN
//   defined   - RUN also ends when cycle_count reaches MAX_CYCLES (sets timeout)
//   undefined - no limit logic; timeout is tied to 0
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               one-cycle pulse: begin load-then-run (IDLE/DONE only)
//   abort               return to IDLE from any state (highest priority)
//   ld_valid/ld_data/ld_last/ld_ready
//                       program word stream, accepted on ld_valid & ld_ready
//   imem_we/imem_addr/imem_wdata
//                       instruction-memory write port (one strobe per word)
//   cpu_instr           instruction the core is fetching this cycle
//   cpu_reset           core reset, low only while running
//   busy                in LOAD or RUN
//   done / timeout      run ended on halt word / on cycle limit
//   cycle_count         run cycles (saturating), frozen after the run
//   words_loaded        words written by the last load
//
// State | meaning
//   IDLE | core held in reset, waiting for start
//   LOAD | accepting program words into instruction memory
//   RUN  | core released, counting cycles, watching for halt
//   DONE | run finished, results held until the next start
//
// All outputs are registered; each *_d is the value they take after the edge.

`timescale 1ns/1ps

module mips_run_controller #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] HALT_WORD  = 32'h0000000C,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       cpu_instr,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   WL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};
  localparam logic [31:0]       CNT_MAX  = 32'hFFFF_FFFF;

  state_t              state_q, state_d;
  logic                ld_ready_q, ld_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         cycle_count_q, cycle_count_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
`ifdef RUN_CTRL_TIMEOUT_EN
  logic                timeout_q, timeout_d;
`endif

  logic                accept;
  logic                at_top_addr;
  logic [31:0]         cnt_inc;

  // ld_ready_q is only ever 1 in LOAD, so it alone qualifies the handshake.
  assign accept      = ld_valid && ld_ready_q;
  assign at_top_addr = (words_loaded_q[ADDR_W-1:0] == ADDR_TOP);
  assign cnt_inc     = (cycle_count_q == CNT_MAX) ? cycle_count_q
                                                  : cycle_count_q + 32'd1;

  always_comb begin
    state_d        = state_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    done_d         = done_q;
    cycle_count_d  = cycle_count_q;
    words_loaded_d = words_loaded_q;
`ifdef RUN_CTRL_TIMEOUT_EN
    timeout_d      = timeout_q;
`endif

    if (abort) begin
      // Counters and flags are left as they are so the aborted run can be
      // inspected; only the next start clears them.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d        = S_LOAD;
            done_d         = 1'b0;
            cycle_count_d  = '0;
            words_loaded_d = '0;
`ifdef RUN_CTRL_TIMEOUT_EN
            timeout_d      = 1'b0;
`endif
          end
        end

        S_LOAD: begin
          if (accept) begin
            imem_we_d      = 1'b1;
            imem_addr_d    = words_loaded_q[ADDR_W-1:0];
            imem_wdata_d   = ld_data;
            words_loaded_d = words_loaded_q + WL_ONE;
            // A full memory ends the load even without ld_last; ld_ready
            // drops with the state change so no further word is taken.
            if (ld_last || at_top_addr) begin
              state_d = S_RUN;
            end
          end
        end

        S_RUN: begin
          cycle_count_d = cnt_inc;
          if (cpu_instr == HALT_WORD) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
`ifdef RUN_CTRL_TIMEOUT_EN
          if (cnt_inc == MAX_CYCLES) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
`endif
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Status outputs follow the next state so they change with it.
    cpu_reset_d = (state_d != S_RUN);
    ld_ready_d  = (state_d == S_LOAD);
    busy_d      = (state_d == S_LOAD) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ld_ready_q     <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cycle_count_q  <= '0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      ld_ready_q     <= ld_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cycle_count_q  <= cycle_count_d;
      words_loaded_q <= words_loaded_d;
    end
  end

`ifdef RUN_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // No limit logic in this build; MAX_CYCLES stays on the interface so the
  // instantiation is the same either way.
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
  assign timeout           = 1'b0;
`endif

  assign ld_ready     = ld_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cycle_count  = cycle_count_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_mips_run_controller.sv
`timescale 1ns/1ps

module tb_mips_run_controller;

  localparam logic [31:0] HALT = 32'h0000000C;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance, ADDR_W = 8
  logic        start, abort, ld_valid, ld_last;
  logic [31:0] ld_data;
  logic        ld_ready, imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata, cpu_instr;
  logic        cpu_reset, busy, done, timeout;
  logic [31:0] cycle_count;
  logic [8:0]  words_loaded;

  // small instance, ADDR_W = 2
  logic        start_s, abort_s, ld_valid_s, ld_last_s;
  logic [31:0] ld_data_s;
  logic        ld_ready_s, imem_we_s;
  logic [1:0]  imem_addr_s;
  logic [31:0] imem_wdata_s, cpu_instr_s;
  logic        cpu_reset_s, busy_s, done_s, timeout_s;
  logic [31:0] cycle_count_s;
  logic [2:0]  words_loaded_s;

  mips_run_controller #(.ADDR_W(8), .MAX_CYCLES(32'd20)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_instr(cpu_instr), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count), .words_loaded(words_loaded)
  );

  mips_run_controller #(.ADDR_W(2)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
    .ld_valid(ld_valid_s), .ld_data(ld_data_s), .ld_last(ld_last_s), .ld_ready(ld_ready_s),
    .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
    .cpu_instr(cpu_instr_s), .cpu_reset(cpu_reset_s), .busy(busy_s), .done(done_s),
    .timeout(timeout_s), .cycle_count(cycle_count_s), .words_loaded(words_loaded_s)
  );

  // Environment: instruction memory plus a core that fetches sequentially
  // from address 0 once released. Writes are logged for the scoreboard.
  logic [31:0] mem [0:255];
  logic [7:0]  pc;
  logic [39:0] wq[$];
  logic [33:0] wq_s[$];

  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      wq.push_back({imem_addr, imem_wdata});
    end
    if (imem_we_s) wq_s.push_back({imem_addr_s, imem_wdata_s});
    pc <= cpu_reset ? 8'd0 : pc + 8'd1;
  end

  assign cpu_instr   = mem[pc];
  assign cpu_instr_s = 32'h0;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] prog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] non_halt();
    logic [31:0] r;
    r = $urandom;
    if (r == HALT) r = r ^ 32'h1;
    return r;
  endfunction

  // Streams prog[] into the main instance with optional valid gaps and
  // random (ignored) start pulses. Returns right after the last handshake edge.
  task automatic load_prog(input int gap_pct, input bit poke_start, output int accepted);
    int i;
    int budget;
    bit hs;
    i = 0;
    budget = 400;
    while (i < prog.size() && budget > 0) begin
      ld_valid = ($urandom_range(99) >= gap_pct);
      ld_data  = prog[i];
      ld_last  = (i == prog.size() - 1);
      start    = poke_start && ($urandom_range(7) == 0);
      hs       = ld_valid && ld_ready;
      tick();
      if (hs) i++;
      budget--;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    start    = 1'b0;
    accepted = i;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wq.size(), prog.size());
    for (int j = 0; j < prog.size() && j < wq.size(); j++) begin
      check($sformatf("%s_addr%0d", tag, j), wq[j][39:32], j);
      check($sformatf("%s_data%0d", tag, j), wq[j][31:0], prog[j]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n, k, len;

    reset = 1'b1;
    start = 0; abort = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    start_s = 0; abort_s = 0; ld_valid_s = 0; ld_last_s = 0; ld_data_s = '0;
    #40;
    reset = 1'b0;
    #1;

    // reset state
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_s_cpu_reset", cpu_reset_s, 1);
    tick();
    check("idle_busy", busy, 0);

    // 4-word program with halt at word 3
    prog = '{non_halt(), non_halt(), non_halt(), HALT};
    pulse_start();
    check("start_ld_ready", ld_ready, 1);
    check("start_busy", busy, 1);
    check("start_cpu_reset", cpu_reset, 1);
    wq.delete();
    load_prog(0, 1'b0, acc);
    check("d4_accepted", acc, 4);
    check("d4_cpu_reset_fall", cpu_reset, 0);
    check("d4_words_loaded", words_loaded, 4);
    check("d4_ld_ready", ld_ready, 0);
    check("d4_last_we", imem_we, 1);
    check("d4_last_addr", imem_addr, 3);
    tick(); tick(); tick();
    check("d4_done_early", done, 0);
    check("d4_running", cpu_reset, 0);
    tick();
    check("d4_done", done, 1);
    check("d4_cpu_reset_halt", cpu_reset, 1);
    check("d4_cycle_count", cycle_count, 4);
    check("d4_busy", busy, 0);
    check("d4_timeout", timeout, 0);
    check_writes("d4");
    tick(); tick();
    check("d4_count_frozen", cycle_count, 4);

    // ADDR_W=2: 6 words offered, no ld_last
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    wq_s.delete();
    acc = 0;
    for (int step = 0; step < 10 && acc < 6; step++) begin
      bit hs;
      ld_valid_s = 1'b1;
      ld_data_s  = 32'hA0 + acc;
      hs = ld_ready_s;
      tick();
      if (hs) acc++;
    end
    ld_valid_s = 1'b0;
    check("cap_accepted", acc, 4);
    check("cap_nwr", wq_s.size(), 4);
    for (int j = 0; j < 4 && j < wq_s.size(); j++) begin
      check($sformatf("cap_addr%0d", j), wq_s[j][33:32], j);
      check($sformatf("cap_data%0d", j), wq_s[j][31:0], 32'hA0 + j);
    end
    check("cap_words_loaded", words_loaded_s, 4);
    check("cap_ld_ready", ld_ready_s, 0);
    check("cap_run", cpu_reset_s, 0);
    check("cap_busy", busy_s, 1);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    check("cap_abort_cpu_reset", cpu_reset_s, 1);
    check("cap_abort_busy", busy_s, 0);

    // abort mid-run at cycle_count 10
    pulse_start();
    check("rs_cycle_clr", cycle_count, 0);
    check("rs_done_clr", done, 0);
    check("rs_words_clr", words_loaded, 0);
    prog.delete();
    for (int j = 0; j < 12; j++) prog.push_back(non_halt());
    load_prog(30, 1'b1, acc);
    n = 0;
    while (cycle_count != 10 && n < 50) begin
      tick();
      n++;
    end
    check("ab_reach10", cycle_count, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_cpu_reset", cpu_reset, 1);
    check("ab_ld_ready", ld_ready, 0);
    check("ab_imem_we", imem_we, 0);
    check("ab_cycle_count", cycle_count, 10);
    check("ab_words_loaded", words_loaded, 12);
    tick();
    check("ab_idle_hold", cycle_count, 10);
    pulse_start();
    check("ab_restart_clr", cycle_count, 0);
    check("ab_restart_load", ld_ready, 1);

    // randomized programs: halt at index k, gaps, ignored start pulses
    for (int it = 0; it < 8; it++) begin
      if (it > 0) pulse_start();
      wq.delete();
      len = $urandom_range(12, 2);
      k   = $urandom_range(len - 1, 0);
      prog.delete();
      for (int j = 0; j < len; j++) prog.push_back((j == k) ? HALT : non_halt());
      load_prog(25, 1'b1, acc);
      check($sformatf("r%0d_words", it), words_loaded, len);
      n = 0;
      while (!done && n < 40) begin
        start = !cpu_reset && ($urandom_range(3) == 0);
        tick();
        n++;
      end
      start = 1'b0;
      check($sformatf("r%0d_done", it), done, 1);
      check($sformatf("r%0d_cycles", it), cycle_count, k + 1);
      check($sformatf("r%0d_busy", it), busy, 0);
      check($sformatf("r%0d_cpu_reset", it), cpu_reset, 1);
      check($sformatf("r%0d_timeout", it), timeout, 0);
      check_writes($sformatf("r%0d", it));
    end

    // program without halt: cycle limit or endless run
    pulse_start();
    prog.delete();
    for (int j = 0; j < 32; j++) prog.push_back(non_halt());
    load_prog(0, 1'b0, acc);
`ifdef RUN_CTRL_TIMEOUT_EN
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("to_timeout", timeout, 1);
    check("to_done", done, 0);
    check("to_cycles", cycle_count, 20);
    check("to_cpu_reset", cpu_reset, 1);
    check("to_busy", busy, 0);
`else
    for (int j = 0; j < 30; j++) tick();
    check("nl_timeout", timeout, 0);
    check("nl_busy", busy, 1);
    check("nl_cpu_reset", cpu_reset, 0);
    check("nl_cycles", cycle_count, 30);
`endif

    // abort and start together: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_ld_ready", ld_ready, 0);
    check("sa_cpu_reset", cpu_reset, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
